// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the whack-a-mole button input stage.
// Debounce FSM state encoding plus width helpers used by the interface and RTL.
package whack_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 5000;
  localparam int DEFAULT_N_BTN           = 4;

  // press_idx width; a single channel still gets a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-stage bus: raw buttons and game enable in, debounced levels and press events out.
// btn_release exists only when BTN_RELEASE_PULSE_EN is defined.
interface button_conditioner_if
  import whack_pkg::*;
#(
  parameter int N_BTN = DEFAULT_N_BTN,
  parameter int IDX_W = idx_width(N_BTN)
);

  logic [N_BTN-1:0] btn_raw;
  logic             en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             press_valid;
  logic [IDX_W-1:0] press_idx;
  logic             multi_press;
`ifdef BTN_RELEASE_PULSE_EN
  logic [N_BTN-1:0] btn_release;
`endif

  modport master (
    output btn_raw,
    output en,
    input  btn_level,
    input  btn_press,
    input  press_valid,
    input  press_idx,
`ifdef BTN_RELEASE_PULSE_EN
    input  btn_release,
`endif
    input  multi_press
  );

  modport slave (
    input  btn_raw,
    input  en,
    output btn_level,
    output btn_press,
    output press_valid,
    output press_idx,
`ifdef BTN_RELEASE_PULSE_EN
    output btn_release,
`endif
    output multi_press
  );

endinterface

// File: rtl/button_conditioner_debounce_ch.sv
// One button channel: 2-flop synchroniser then a 4-state debounce FSM with a saturating counter.
// level/rise/fall are registered; fall port exists only with BTN_RELEASE_PULSE_EN.
module btn_debounce_ch
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
`ifdef BTN_RELEASE_PULSE_EN
  output logic fall,
`endif
  output logic rise
);

  localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             meta;
  logic             sync;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // cnt tracks how many consecutive sync samples disagree with the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_LOW;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        S_LOW: begin
          if (sync) begin
            state <= S_RISE;
            cnt   <= ONE;
          end else begin
            cnt   <= '0;
          end
        end
        S_RISE: begin
          if (!sync) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= S_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!sync) begin
            state <= S_FALL;
            cnt   <= ONE;
          end else begin
            cnt   <= '0;
          end
        end
        S_FALL: begin
          if (sync) begin
            state  <= S_HIGH;
            cnt    <= '0;
          end else if (cnt == LAST) begin
            state  <= S_LOW;
            cnt    <= '0;
            level  <= 1'b0;
            fall_q <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_RELEASE_PULSE_EN
  assign fall = fall_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Whack-a-mole button stage: per-channel debounce, en-gated press pulses, lowest-index hit encoding.
// BTN_RELEASE_PULSE_EN adds en-gated btn_release pulses on debounced falling edges.
module button_conditioner
  import whack_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int IDX_W = idx_width(N_BTN);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] press;
  logic [IDX_W-1:0] idx;
  logic             en_q;
`ifdef BTN_RELEASE_PULSE_EN
  logic [N_BTN-1:0] fall;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_raw[i]),
      .level(level[i]),
`ifdef BTN_RELEASE_PULSE_EN
      .fall (fall[i]),
`endif
      .rise (rise[i])
    );
  end

  // en is captured on the same edge as rise so the gate reflects en at the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= bus.en;
    end
  end

  assign press = rise & {N_BTN{en_q}};

  always_comb begin
    idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.press_valid = |press;
  assign bus.press_idx   = idx;
  assign bus.multi_press = |(press & (press - 1'b1));
`ifdef BTN_RELEASE_PULSE_EN
  assign bus.btn_release = fall & {N_BTN{en_q}};
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus a random soak,
// each cycle compared against a sliding-window debounce model.
module tb_button_conditioner;
  import whack_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int IW = idx_width(N);
`ifdef BTN_RELEASE_PULSE_EN
  localparam int VW = 3 * N + IW + 2;
`else
  localparam int VW = 2 * N + IW + 2;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: sync value at an edge is btn_raw from two edges earlier; a level flips once
  // the last D sync samples all disagree with it.
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] sync_win[$];
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_rel;

  task automatic model_clear();
    raw_hist.delete();
    sync_win.delete();
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    logic [N-1:0] flip;
    if (rst) begin
      model_clear();
      return;
    end
    s = (raw_hist.size() == 2) ? raw_hist[0] : '0;
    raw_hist.push_back(bus.btn_raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    sync_win.push_back(s);
    if (sync_win.size() > D) void'(sync_win.pop_front());
    for (int i = 0; i < N; i++) begin
      flip[i] = (sync_win.size() == D);
      foreach (sync_win[j]) if (sync_win[j][i] == m_level[i]) flip[i] = 1'b0;
    end
    m_press = flip & ~m_level & {N{bus.en}};
    m_rel   = flip &  m_level & {N{bus.en}};
    m_level = m_level ^ flip;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (m_press[i]) idx = IW'(i);
`ifdef BTN_RELEASE_PULSE_EN
    return {m_level, m_press, |m_press, idx, ($countones(m_press) > 1), m_rel};
`else
    return {m_level, m_press, |m_press, idx, ($countones(m_press) > 1)};
`endif
  endfunction

  function automatic logic [VW-1:0] dut_vec();
`ifdef BTN_RELEASE_PULSE_EN
    return {bus.btn_level, bus.btn_press, bus.press_valid, bus.press_idx, bus.multi_press,
            bus.btn_release};
`else
    return {bus.btn_level, bus.btn_press, bus.press_valid, bus.press_idx, bus.multi_press};
`endif
  endfunction

  task automatic idle(input int n);
    bus.btn_raw = '0;
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_raw = '0;
    bus.en = 1'b0;
    model_clear();
    repeat (3) cycle();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", dut_vec());
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    bus.en = 1'b1;
    bus.btn_raw = 4'b0100;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      checks++;
      if (bus.btn_press !== ((k == D + 2) ? 4'b0100 : 4'b0000) ||
          bus.btn_level[2] !== 1'(k >= D + 2)) begin
        errors++;
        $display("FAIL clean_timing k=%0d: press=%b level=%b", k, bus.btn_press, bus.btn_level);
      end
      if (k == D + 2) begin
        checks++;
        if (bus.press_valid !== 1'b1 || bus.press_idx !== IW'(2) || bus.multi_press !== 1'b0) begin
          errors++;
          $display("FAIL clean_encode: valid=%b idx=%0d multi=%b expected 1 2 0",
                   bus.press_valid, bus.press_idx, bus.multi_press);
        end
      end
    end
    idle(D + 6);
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b10101;
    for (int j = 0; j < 4; j++) begin
      bus.btn_raw = {3'b000, pat[j]};
      cycle();
      checks++;
      if (dut_vec() !== exp_vec() || bus.btn_press !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_toggle j=%0d: got %h expected %h", j, dut_vec(), exp_vec());
      end
    end
    bus.btn_raw = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec() ||
          bus.btn_press !== ((k == D + 2) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_press k=%0d: press=%b got %h expected %h",
                 k, bus.btn_press, dut_vec(), exp_vec());
      end
    end
    idle(D + 6);
  endtask

  task automatic test_simultaneous();
    bus.btn_raw = 4'b1010;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      checks++;
      if (k == D + 2) begin
        if (bus.btn_press !== 4'b1010 || bus.press_valid !== 1'b1 ||
            bus.press_idx !== IW'(1) || bus.multi_press !== 1'b1) begin
          errors++;
          $display("FAIL simul_encode: press=%b valid=%b idx=%0d multi=%b expected 1010 1 1 1",
                   bus.btn_press, bus.press_valid, bus.press_idx, bus.multi_press);
        end
      end else if (bus.press_valid !== 1'b0 || bus.multi_press !== 1'b0) begin
        errors++;
        $display("FAIL simul_quiet k=%0d: valid=%b multi=%b expected 0 0",
                 k, bus.press_valid, bus.multi_press);
      end
    end
    idle(D + 6);
  endtask

  task automatic test_en_gating();
    int presses;
    presses = 0;
    bus.en = 1'b0;
    bus.btn_raw = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      cycle();
      presses += $countones(bus.btn_press);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL en_model: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.btn_level[3] !== 1'b1 || presses != 0) begin
      errors++;
      $display("FAIL en_low: level3=%b presses=%0d expected 1 0", bus.btn_level[3], presses);
    end
    bus.en = 1'b1;
    repeat (8) begin
      cycle();
      presses += $countones(bus.btn_press);
    end
    checks++;
    if (presses != 0) begin
      errors++;
      $display("FAIL en_raise_held: presses=%0d expected 0", presses);
    end
    idle(D + 6);
    bus.btn_raw = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      cycle();
      presses += $countones(bus.btn_press);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL en_repress_model: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL en_repress: presses=%0d expected 1", presses);
    end
    idle(D + 6);
  endtask

  task automatic test_reset_mid();
    bus.en = 1'b1;
    bus.btn_raw = 4'b0001;
    repeat (10) cycle();
    bus.btn_raw = 4'b0011;
    repeat (4) cycle();
    checks++;
    if (bus.btn_level !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_pre: level=%b expected 0001", bus.btn_level);
    end
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got %h expected 0", dut_vec());
    end
    bus.btn_raw = 4'b0010;
    repeat (2) cycle();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec() ||
          bus.btn_press !== ((k == D + 2) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL rstmid_press k=%0d: press=%b got %h expected %h",
                 k, bus.btn_press, dut_vec(), exp_vec());
      end
    end
    idle(D + 6);
  endtask

`ifdef BTN_RELEASE_PULSE_EN
  task automatic test_release();
    bus.en = 1'b1;
    bus.btn_raw = 4'b0010;
    repeat (10) cycle();
    bus.btn_raw = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec() ||
          bus.btn_release !== ((k == D + 2) ? 4'b0010 : 4'b0000) ||
          bus.btn_level[1] !== 1'(k < D + 2)) begin
        errors++;
        $display("FAIL release k=%0d: rel=%b level=%b", k, bus.btn_release, bus.btn_level);
      end
    end
    idle(D + 6);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] r;
      r = bus.btn_raw;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      bus.btn_raw = r;
      if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
          errors++;
          $display("FAIL random_reset c=%0d: got %h expected 0", c, dut_vec());
        end
        cycle();
        rst = 1'b0;
      end
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c=%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
    idle(D + 6);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_en_gating();
    test_reset_mid();
`ifdef BTN_RELEASE_PULSE_EN
    test_release();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
